// File: rtl/dffmem_pkg.sv
// Shared types and helpers for the dffmem_rf flip-flop register file.
// DFFMEM_PARITY_EN adds one even-parity bit per stored byte.
package dffmem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DATA_W_DEFAULT = 16;
  localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;

  // Even parity: the stored bit makes the total count of ones in byte+bit even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dffmem_word.sv
// One storage word with per-byte write enables and a synchronous zeroing input.
// DFFMEM_PARITY_EN adds a per-byte even-parity bit, exposed on port par.
module dffmem_word
  import dffmem_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEFAULT,
  localparam int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [NB-1:0]     wr_be,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] q
`ifdef DFFMEM_PARITY_EN
  ,
  output logic [NB-1:0]     par
`endif
);

  logic [DATA_W-1:0] data_reg;
`ifdef DFFMEM_PARITY_EN
  logic [NB-1:0]     par_reg;
`endif

  // Storage is deliberately not reset; the top-level sweep zeroes it.
  always_ff @(posedge clk) begin
    if (clr) begin
      data_reg <= '0;
`ifdef DFFMEM_PARITY_EN
      par_reg  <= '0;
`endif
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          data_reg[8*b +: 8] <= wr_data[8*b +: 8];
`ifdef DFFMEM_PARITY_EN
          par_reg[b]         <= byte_parity(wr_data[8*b +: 8]);
`endif
        end
      end
    end
  end

  assign q = data_reg;
`ifdef DFFMEM_PARITY_EN
  assign par = par_reg;
`endif

endmodule

// File: rtl/dffmem_rf.sv
// Parametrised DFF register file: byte-enable write port, registered read port,
// hardware clear sweep after reset or on clr. DFFMEM_PARITY_EN adds par_err.
module dffmem_rf
  import dffmem_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEFAULT,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NB-1:0]     wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
`ifdef DFFMEM_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              accept;

  logic [DATA_W-1:0] word_q [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg;
`ifdef DFFMEM_PARITY_EN
  logic [NB-1:0]     word_par [DEPTH];
  logic [NB-1:0]     rd_par;
  logic              rd_perr;
  logic              par_err_reg;
`endif

  // A clr in IDLE pre-empts both ports in the same cycle.
  assign accept = (state_reg == IDLE) && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        if (cnt_reg == LAST_ADDR) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_word
      logic sweep_sel;
      logic write_sel;
      assign sweep_sel = (state_reg == CLEAR) && (cnt_reg == ADDR_W'(gi));
      assign write_sel = accept && wr_en && (wr_addr == ADDR_W'(gi));

      dffmem_word #(.DATA_W(DATA_W)) u_word (
        .clk     (clk),
        .clr     (sweep_sel),
        .wr_en   (write_sel),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .q       (word_q[gi])
`ifdef DFFMEM_PARITY_EN
        ,
        .par     (word_par[gi])
`endif
      );
    end
  endgenerate

  // Addresses at or beyond DEPTH match no word and read back as zero.
  always_comb begin
    rd_word = '0;
`ifdef DFFMEM_PARITY_EN
    rd_par  = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_word = word_q[i];
`ifdef DFFMEM_PARITY_EN
        rd_par  = word_par[i];
`endif
      end
    end
  end

`ifdef DFFMEM_PARITY_EN
  always_comb begin
    rd_perr = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (rd_par[b] != byte_parity(rd_word[8*b +: 8])) rd_perr = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
`ifdef DFFMEM_PARITY_EN
      par_err_reg  <= 1'b0;
`endif
    end else if (accept && rd_en) begin
      rd_data_reg  <= rd_word;
      rd_valid_reg <= 1'b1;
`ifdef DFFMEM_PARITY_EN
      par_err_reg  <= rd_perr;
`endif
    end else begin
      rd_valid_reg <= 1'b0;
`ifdef DFFMEM_PARITY_EN
      par_err_reg  <= 1'b0;
`endif
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign busy     = (state_reg == CLEAR);
`ifdef DFFMEM_PARITY_EN
  assign par_err  = par_err_reg;
`endif

endmodule
